// File: rtl/img_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_disp_pkg
// Description : Shared opcode constants and controller state encoding for
//               the image display controller and its window ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package img_disp_pkg;

  localparam logic [3:0] CMD_WRITE    = 4'h0;
  localparam logic [3:0] CMD_UP       = 4'h1;
  localparam logic [3:0] CMD_DOWN     = 4'h2;
  localparam logic [3:0] CMD_LEFT     = 4'h3;
  localparam logic [3:0] CMD_RIGHT    = 4'h4;
  localparam logic [3:0] CMD_MAX      = 4'h5;
  localparam logic [3:0] CMD_MIN      = 4'h6;
  localparam logic [3:0] CMD_AVG      = 4'h7;
  localparam logic [3:0] CMD_CCW      = 4'h8;
  localparam logic [3:0] CMD_CW       = 4'h9;
  localparam logic [3:0] CMD_MIRX     = 4'hA;
  localparam logic [3:0] CMD_MIRY     = 4'hB;
  localparam logic [3:0] CMD_RELOAD   = 4'hC;
  localparam logic [3:0] CMD_RECENTRE = 4'hD;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/img_win_alu.sv
`default_nettype none
// ============================================================================
// Module      : img_win_alu
// Description : Combinational 2x2 window operator. Produces the new values of
//               the four window pixels for max/min/average/rotate/mirror.
// Ports       : i_op        - command opcode
//               i_p0..i_p3  - current window pixels (TL, TR, BL, BR)
//               o_n0..o_n3  - new window pixels
//               o_we        - high when i_op modifies the window
// Revision    : 1.0 - initial release
// ============================================================================
module img_win_alu
  import img_disp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_p0,
  input  logic [DATA_W-1:0] i_p1,
  input  logic [DATA_W-1:0] i_p2,
  input  logic [DATA_W-1:0] i_p3,
  output logic [DATA_W-1:0] o_n0,
  output logic [DATA_W-1:0] o_n1,
  output logic [DATA_W-1:0] o_n2,
  output logic [DATA_W-1:0] o_n3,
  output logic              o_we
);

  logic [DATA_W-1:0] w_max01, w_max23, w_max;
  logic [DATA_W-1:0] w_min01, w_min23, w_min;
  logic [DATA_W+1:0] w_sum;
  logic [DATA_W-1:0] w_avg;

  assign w_max01 = (i_p0 > i_p1) ? i_p0 : i_p1;
  assign w_max23 = (i_p2 > i_p3) ? i_p2 : i_p3;
  assign w_max   = (w_max01 > w_max23) ? w_max01 : w_max23;
  assign w_min01 = (i_p0 < i_p1) ? i_p0 : i_p1;
  assign w_min23 = (i_p2 < i_p3) ? i_p2 : i_p3;
  assign w_min   = (w_min01 < w_min23) ? w_min01 : w_min23;

  // Two guard bits keep the four-pixel sum exact before the divide by four.
  assign w_sum = {2'b00, i_p0} + {2'b00, i_p1} + {2'b00, i_p2} + {2'b00, i_p3};
  assign w_avg = DATA_W'(w_sum >> 2);

  always_comb begin
    o_n0 = i_p0;
    o_n1 = i_p1;
    o_n2 = i_p2;
    o_n3 = i_p3;
    o_we = 1'b0;
    case (i_op)
      CMD_MAX:  begin o_n0 = w_max; o_n1 = w_max; o_n2 = w_max; o_n3 = w_max; o_we = 1'b1; end
      CMD_MIN:  begin o_n0 = w_min; o_n1 = w_min; o_n2 = w_min; o_n3 = w_min; o_we = 1'b1; end
      CMD_AVG:  begin o_n0 = w_avg; o_n1 = w_avg; o_n2 = w_avg; o_n3 = w_avg; o_we = 1'b1; end
      CMD_CCW:  begin o_n0 = i_p1;  o_n1 = i_p3;  o_n3 = i_p2;  o_n2 = i_p0;  o_we = 1'b1; end
      CMD_CW:   begin o_n0 = i_p2;  o_n2 = i_p3;  o_n3 = i_p1;  o_n1 = i_p0;  o_we = 1'b1; end
      CMD_MIRX: begin o_n0 = i_p2;  o_n2 = i_p0;  o_n1 = i_p3;  o_n3 = i_p1;  o_we = 1'b1; end
      CMD_MIRY: begin o_n0 = i_p1;  o_n1 = i_p0;  o_n2 = i_p3;  o_n3 = i_p2;  o_we = 1'b1; end
      default:  ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/img_disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : img_disp_ctrl
// Description : Image display controller. Loads a W x H image from a
//               synchronous ROM into a frame buffer, applies 2x2 cursor-window
//               commands, and streams the buffer to an image RAM on request.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               cmd, cmd_valid       - command opcode / strobe
//               IROM_Q/IROM_rd/IROM_A - image ROM read port
//               IRAM_valid/D/A       - image RAM write port
//               busy                 - commands ignored while high
//               done                 - one-cycle pulse at end of write-out
// Revision    : 1.0 - initial release
// ============================================================================
module img_disp_ctrl
  import img_disp_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int IMG_W  = 8,
  parameter  int IMG_H  = 8,
  localparam int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic              IROM_rd,
  output logic [ADDR_W-1:0] IROM_A,
  output logic              IRAM_valid,
  output logic [DATA_W-1:0] IRAM_D,
  output logic [ADDR_W-1:0] IRAM_A,
  output logic              busy,
  output logic              done
);

  localparam int c_N     = IMG_W * IMG_H;
  localparam int c_XW    = $clog2(IMG_W);
  localparam int c_YW    = $clog2(IMG_H);
  localparam int c_CNT_W = ADDR_W + 1;

  localparam logic [c_XW-1:0]    c_X_CTR   = c_XW'(IMG_W / 2);
  localparam logic [c_XW-1:0]    c_X_MAX   = c_XW'(IMG_W - 1);
  localparam logic [c_XW-1:0]    c_X_MIN   = c_XW'(1);
  localparam logic [c_YW-1:0]    c_Y_CTR   = c_YW'(IMG_H / 2);
  localparam logic [c_YW-1:0]    c_Y_MAX   = c_YW'(IMG_H - 1);
  localparam logic [c_YW-1:0]    c_Y_MIN   = c_YW'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_END = c_CNT_W'(c_N);

  state_t              r_state, w_next;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_XW-1:0]     r_x;
  logic [c_YW-1:0]     r_y;
  logic [DATA_W-1:0]   r_buf [c_N];

  logic                w_accept, w_cnt_end, w_we;
  logic [ADDR_W-1:0]   w_a0, w_a1, w_a2, w_a3, w_idx;
  logic [DATA_W-1:0]   w_n0, w_n1, w_n2, w_n3;

  // Commands are only taken in CMD; busy is simply "not in CMD".
  assign busy      = (r_state != ST_CMD);
  assign w_accept  = cmd_valid && (r_state == ST_CMD);
  assign w_cnt_end = (r_cnt == c_CNT_END);
  assign w_idx     = r_cnt[ADDR_W-1:0];

  // Power-of-two dimensions make the row-major address a plain {y, x}.
  assign w_a0 = {r_y - c_Y_MIN, r_x - c_X_MIN};
  assign w_a1 = {r_y - c_Y_MIN, r_x};
  assign w_a2 = {r_y, r_x - c_X_MIN};
  assign w_a3 = {r_y, r_x};

  img_win_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op (cmd),
    .i_p0 (r_buf[w_a0]),
    .i_p1 (r_buf[w_a1]),
    .i_p2 (r_buf[w_a2]),
    .i_p3 (r_buf[w_a3]),
    .o_n0 (w_n0),
    .o_n1 (w_n1),
    .o_n2 (w_n2),
    .o_n3 (w_n3),
    .o_we (w_we)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD:  if (w_cnt_end) w_next = ST_CMD;
      ST_CMD: begin
        if (w_accept && cmd == CMD_WRITE)       w_next = ST_WRITE;
        else if (w_accept && cmd == CMD_RELOAD) w_next = ST_LOAD;
      end
      ST_WRITE: if (w_cnt_end) w_next = ST_CMD;
      default:  w_next = ST_LOAD;
    endcase
  end

  // Frame buffer: no reset, contents are reloaded from ROM after any reset.
  // A ROM read issued on the previous edge is captured at the address it used.
  always_ff @(posedge clk) begin
    if (!reset && IROM_rd) r_buf[IROM_A] <= IROM_Q;
    if (!reset && w_accept && w_we) begin
      r_buf[w_a0] <= w_n0;
      r_buf[w_a1] <= w_n1;
      r_buf[w_a2] <= w_n2;
      r_buf[w_a3] <= w_n3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_x        <= c_X_CTR;
      r_y        <= c_Y_CTR;
      IROM_rd    <= 1'b0;
      IROM_A     <= '0;
      IRAM_valid <= 1'b0;
      IRAM_A     <= '0;
      IRAM_D     <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (!w_cnt_end) begin
            IROM_rd <= 1'b1;
            IROM_A  <= w_idx;
            r_cnt   <= r_cnt + 1'b1;
          end else begin
            IROM_rd <= 1'b0;
            IROM_A  <= '0;
            r_cnt   <= '0;
          end
        end
        ST_CMD: begin
          r_cnt <= '0;
          if (w_accept) begin
            case (cmd)
              CMD_UP:    if (r_y > c_Y_MIN) r_y <= r_y - 1'b1;
              CMD_DOWN:  if (r_y < c_Y_MAX) r_y <= r_y + 1'b1;
              CMD_LEFT:  if (r_x > c_X_MIN) r_x <= r_x - 1'b1;
              CMD_RIGHT: if (r_x < c_X_MAX) r_x <= r_x + 1'b1;
              CMD_RELOAD, CMD_RECENTRE: begin
                r_x <= c_X_CTR;
                r_y <= c_Y_CTR;
              end
              default: ;
            endcase
          end
        end
        ST_WRITE: begin
          if (!w_cnt_end) begin
            IRAM_valid <= 1'b1;
            IRAM_A     <= w_idx;
            IRAM_D     <= r_buf[w_idx];
            r_cnt      <= r_cnt + 1'b1;
          end else begin
            IRAM_valid <= 1'b0;
            done       <= 1'b1;
            r_cnt      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_img_disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_img_disp_ctrl
// Description : Self-checking bench for img_disp_ctrl. Two instances share the
//               command inputs: an 8x8x8 and a 16x4x10 configuration; the one
//               not under test is held in reset. A behavioural image model
//               predicts every write-out stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_img_disp_ctrl;
  import img_disp_pkg::*;

  localparam int N = 64;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd = 4'h0;
  bit         sel = 1'b0;

  logic       rd_a, rd_b, rv_a, rv_b, busy_a, busy_b, done_a, done_b;
  logic [5:0] ia_a, ia_b, ra_a, ra_b;
  logic [7:0] q_a, d_a;
  logic [9:0] q_b, d_b;
  logic [7:0] rom_a [N];
  logic [9:0] rom_b [N];

  logic       o_rd, o_rv, o_busy, o_done;
  logic [5:0] o_ia, o_ra;
  logic [9:0] o_d;

  always #5 clk = ~clk;

  assign q_a    = rom_a[ia_a];
  assign q_b    = rom_b[ia_b];
  assign o_rd   = sel ? rd_b   : rd_a;
  assign o_rv   = sel ? rv_b   : rv_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_ia   = sel ? ia_b   : ia_a;
  assign o_ra   = sel ? ra_b   : ra_a;
  assign o_d    = sel ? d_b    : {2'b00, d_a};

  img_disp_ctrl u_dut_a (
    .clk(clk), .reset(rst_a), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_Q(q_a), .IROM_rd(rd_a), .IROM_A(ia_a),
    .IRAM_valid(rv_a), .IRAM_D(d_a), .IRAM_A(ra_a),
    .busy(busy_a), .done(done_a)
  );

  img_disp_ctrl #(.DATA_W(10), .IMG_W(16), .IMG_H(4)) u_dut_b (
    .clk(clk), .reset(rst_b), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_Q(q_b), .IROM_rd(rd_b), .IROM_A(ia_b),
    .IRAM_valid(rv_b), .IRAM_D(d_b), .IRAM_A(ra_b),
    .busy(busy_b), .done(done_b)
  );

  int nvec = 0, nfail = 0;
  int mbuf [N];
  int got  [N];
  int mx, my, mw, mh;

  typedef struct {
    logic [3:0] op;
    bit         chk;
    int         idx;
    int         exp;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural image model ----------------
  function automatic int rom_val(input int i);
    return sel ? int'(rom_b[i]) : int'(rom_a[i]);
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic int min4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    if (d < m) m = d;
    return m;
  endfunction

  function automatic void m_load;
    for (int i = 0; i < N; i++) mbuf[i] = rom_val(i);
    mx = mw / 2;
    my = mh / 2;
  endfunction

  function automatic void m_cmd(input int op);
    int k[4];
    int p[4];
    int n[4];
    k[0] = (my - 1) * mw + mx - 1;
    k[1] = (my - 1) * mw + mx;
    k[2] = my * mw + mx - 1;
    k[3] = my * mw + mx;
    for (int i = 0; i < 4; i++) begin
      p[i] = mbuf[k[i]];
      n[i] = p[i];
    end
    case (op)
      1:  if (my > 1) my--;
      2:  if (my < mh - 1) my++;
      3:  if (mx > 1) mx--;
      4:  if (mx < mw - 1) mx++;
      5:  for (int i = 0; i < 4; i++) n[i] = max4(p[0], p[1], p[2], p[3]);
      6:  for (int i = 0; i < 4; i++) n[i] = min4(p[0], p[1], p[2], p[3]);
      7:  for (int i = 0; i < 4; i++) n[i] = (p[0] + p[1] + p[2] + p[3]) / 4;
      8:  begin n[0] = p[1]; n[1] = p[3]; n[3] = p[2]; n[2] = p[0]; end
      9:  begin n[0] = p[2]; n[2] = p[3]; n[3] = p[1]; n[1] = p[0]; end
      10: begin n[0] = p[2]; n[2] = p[0]; n[1] = p[3]; n[3] = p[1]; end
      11: begin n[0] = p[1]; n[1] = p[0]; n[2] = p[3]; n[3] = p[2]; end
      12: m_load();
      13: begin mx = mw / 2; my = mh / 2; end
      default: ;
    endcase
    if (op >= 5 && op <= 11)
      for (int i = 0; i < 4; i++) mbuf[k[i]] = n[i];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [3:0] op);
    cmd       = op;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    m_cmd(int'(op));
  endtask

  // Counts edges until busy falls; the first and last ROM reads are checked.
  task automatic wait_busy_low(input string nm, input int exp_edges);
    int n;
    n = 0;
    while (o_busy === 1'b1 && n < 300) begin
      tick();
      n++;
      if (n == 1) chk({nm, "_first_rd"}, {o_rd, o_ia}, {1'b1, 6'd0});
      if (n == N) chk({nm, "_last_rd"}, {o_rd, o_ia}, {1'b1, 6'd63});
    end
    chk({nm, "_edges"}, n, exp_edges);
    chk({nm, "_rom_idle"}, {o_rd, o_ia}, 7'd0);
  endtask

  task automatic do_reset(input bit s, input int w, input int h);
    sel       = s;
    mw        = w;
    mh        = h;
    cmd_valid = 1'b0;
    rst_a     = 1'b1;
    rst_b     = 1'b1;
    tick();
    tick();
    chk("reset_values", {o_busy, o_rd, o_ia, o_rv, o_ra, o_d, o_done},
        {1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 10'd0, 1'b0});
    if (s) rst_b = 1'b0;
    else   rst_a = 1'b0;
    m_load();
    wait_busy_low("load", N + 1);
  endtask

  // Write-out; with noise set, random Max commands are strobed while busy
  // (including the edge on which busy falls) and must be ignored.
  task automatic do_write(input bit noise);
    int bad, bk;
    logic [31:0] bd;
    bad = 0; bk = 0; bd = '0;
    cmd       = CMD_WRITE;
    cmd_valid = 1'b1;
    tick();
    chk("wr_busy_rise", {o_busy, o_rv}, 2'b10);
    cmd       = CMD_MAX;
    cmd_valid = noise & 1'($urandom);
    for (int k = 1; k <= N; k++) begin
      tick();
      got[k-1] = int'(o_d);
      if (!(o_rv === 1'b1 && o_ra === 6'(k - 1) && 32'(o_d) === 32'(mbuf[k-1]) &&
            o_busy === 1'b1 && o_done === 1'b0)) begin
        if (bad == 0) begin bk = k - 1; bd = 32'(o_d); end
        bad++;
      end
      cmd_valid = noise & 1'($urandom);
    end
    chk("wr_stream_bad_beats", bad, 0);
    if (bad != 0) $display("  first bad beat at index %0d, D=%0d, model=%0d", bk, bd, mbuf[bk]);
    tick();
    chk("wr_end_valid_done_busy", {o_rv, o_done, o_busy}, 3'b010);
    cmd_valid = 1'b0;
    tick();
    chk("wr_done_clear_hold", {o_done, o_busy, o_ra}, {1'b0, 1'b0, 6'd63});
  endtask

  function automatic void add(input logic [3:0] op, input bit c, input int idx, input int exp);
    vec_t v;
    v.op = op; v.chk = c; v.idx = idx; v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic run_random(input int iters);
    int r, op;
    for (int it = 0; it < iters; it++) begin
      r = $urandom_range(0, 39);
      if (r == 0) begin
        do_write(1'b1);
      end else if (r == 1) begin
        send(CMD_RELOAD);
        wait_busy_low("rand_reload", N + 1);
      end else begin
        op = $urandom_range(1, 15);
        if (op == 12) op = 13;
        send(4'(op));
        if ($urandom_range(0, 3) == 0) tick();
      end
    end
    do_write(1'b0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Hand-derived window sequence on the 8x8 image with ROM[i] = i.
    for (int i = 0; i < 5; i++) add(CMD_UP, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) add(CMD_LEFT, 1'b0, 0, 0);
    add(CMD_MAX, 1'b1, 0, 9);
    add(4'hE, 1'b1, 9, 9);
    for (int i = 0; i < 9; i++) add(CMD_DOWN, 1'b0, 0, 0);
    add(CMD_MAX, 1'b1, 56, 57);
    add(CMD_RECENTRE, 1'b0, 0, 0);
    add(CMD_CW, 1'b1, 27, 35);
    add(CMD_CCW, 1'b1, 36, 36);
    add(CMD_MIRX, 1'b1, 27, 35);
    add(CMD_MIRY, 1'b1, 27, 36);
    add(CMD_MIN, 1'b1, 36, 27);
    add(CMD_RIGHT, 1'b0, 0, 0);
    add(CMD_AVG, 1'b1, 29, 30);

    for (int i = 0; i < N; i++) begin
      rom_a[i] = 8'(i);
      rom_b[i] = 10'($urandom);
    end

    // ---- 8x8 instance ----
    do_reset(1'b0, 8, 8);
    do_write(1'b0);
    chk("first_stream_last", got[63], 63);

    foreach (tbl[i]) begin
      send(tbl[i].op);
      if (tbl[i].chk) begin
        do_write(1'b0);
        chk($sformatf("tbl_%0d_op%0h_buf%0d", i, tbl[i].op, tbl[i].idx), got[tbl[i].idx], tbl[i].exp);
      end
    end

    // Average of near-full-scale values must not overflow.
    rom_a[27] = 8'd255; rom_a[28] = 8'd255; rom_a[35] = 8'd255; rom_a[36] = 8'd254;
    send(CMD_RELOAD);
    wait_busy_low("reload_a", N + 1);
    send(CMD_AVG);
    do_write(1'b0);
    chk("avg_no_overflow", got[27], 254);
    send(CMD_MIN);
    do_write(1'b1);
    chk("min_after_avg", got[35], 254);

    for (int i = 0; i < N; i++) rom_a[i] = 8'($urandom);
    send(CMD_RELOAD);
    wait_busy_low("reload_rand_a", N + 1);
    run_random(300);

    // ---- 16x4x10 instance ----
    do_reset(1'b1, 16, 4);
    send(CMD_MAX);
    do_write(1'b0);
    chk("b_centre_max", got[40],
        max4(int'(rom_b[23]), int'(rom_b[24]), int'(rom_b[39]), int'(rom_b[40])));
    for (int i = 0; i < 20; i++) send(CMD_RIGHT);
    send(CMD_MAX);
    do_write(1'b0);
    chk("b_right_saturate", got[47],
        max4(int'(rom_b[30]), int'(rom_b[31]), int'(rom_b[46]), int'(rom_b[47])));
    run_random(200);

    // Reset in the middle of a write-out.
    cmd       = CMD_WRITE;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (10) tick();
    chk("b_mid_write_valid", o_rv, 1'b1);
    rst_b = 1'b1;
    tick();
    chk("b_reset_mid_write", {o_rv, o_busy}, 2'b01);
    rst_b = 1'b0;
    m_load();
    wait_busy_low("b_reload_after_reset", N + 1);

    // Edits followed by Reload must restore ROM contents.
    send(CMD_MAX);
    send(CMD_AVG);
    send(CMD_CW);
    send(CMD_RELOAD);
    wait_busy_low("b_reload_cmd", N + 1);
    do_write(1'b0);
    chk("b_reload_restores", got[40], int'(rom_b[40]));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
